// File: rtl/host_line_if.sv
// host_line_if: cache-line host request/response bundle between mem_ctrl and its host responder
interface host_line_if #(
    parameter int ADDR_BITCOUNT = 64,
    parameter int CL_SIZE_WIDTH = 512
);
    logic                     host_re;
    logic                     host_we;
    logic [ADDR_BITCOUNT-1:0] corrected_address;
    logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;
    logic                     host_init;
    logic                     host_rd_ready;
    logic                     host_wr_ready;
    logic                     host_rd_valid;
    logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
    modport master (
        output host_re, host_we, corrected_address, host_data_bus_write_out,
        input  host_init, host_rd_ready, host_wr_ready, host_rd_valid, host_data_bus_read_in
    );
    modport slave (
        input  host_re, host_we, corrected_address, host_data_bus_write_out,
        output host_init, host_rd_ready, host_wr_ready, host_rd_valid, host_data_bus_read_in
    );
endinterface

// File: rtl/host_line_responder.sv
// host_line_responder: line-addressed backing store answering mem_ctrl host requests with fixed read latency
module host_line_responder #(
    parameter int                       ADDR_BITCOUNT = 64,
    parameter int                       CL_SIZE_WIDTH = 512,
    parameter int                       DEPTH_LOG2    = 6,
    parameter int                       RD_LATENCY    = 4,
    parameter logic [CL_SIZE_WIDTH-1:0] FILL_VALUE    = '1
) (
    input logic       clk,
    input logic       rst_n,
    host_line_if.slave bus
);
    typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RD_RESP, WR_BUSY} state_t;
    state_t                   state, state_nx;
    logic [CL_SIZE_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [ADDR_BITCOUNT-1:0] addr;
    logic [DEPTH_LOG2-1:0]    idx, init_cnt, rd_idx, wr_idx;
    logic [3:0]               lat_cnt;
    logic [CL_SIZE_WIDTH-1:0] wr_data;
    logic                     open, wr_acc, rd_acc, mem_we;
    assign addr    = bus.corrected_address;
    assign idx     = addr[6 +: DEPTH_LOG2];
    // RD_RESP fetches the line; the registered valid cycle that follows still blocks new requests
    assign open    = state == IDLE && !bus.host_rd_valid;
    assign wr_acc  = open && bus.host_we;
    assign rd_acc  = open && bus.host_re && !bus.host_we;
    assign mem_we  = state == INIT || wr_acc;
    assign wr_idx  = state == INIT ? init_cnt : idx;
    assign wr_data = state == INIT ? FILL_VALUE : bus.host_data_bus_write_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state == INIT    ? (init_cnt == '1 ? IDLE : INIT) :
                   state == IDLE    ? (wr_acc ? WR_BUSY : rd_acc ? (RD_LATENCY == 1 ? RD_RESP : RD_WAIT) : IDLE) :
                   state == RD_WAIT ? (lat_cnt == 4'd1 ? RD_RESP : RD_WAIT) :
                   IDLE;
    end
    always_comb begin
        bus.host_rd_ready = open;
        bus.host_wr_ready = open;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt                  <= '0;
            lat_cnt                   <= '0;
            rd_idx                    <= '0;
            bus.host_init             <= 1'b0;
            bus.host_rd_valid         <= 1'b0;
            bus.host_data_bus_read_in <= '0;
        end else begin
            init_cnt                  <= state == INIT ? init_cnt + DEPTH_LOG2'(1) : init_cnt;
            lat_cnt                   <= rd_acc ? 4'(RD_LATENCY - 1) : state == RD_WAIT ? lat_cnt - 4'd1 : lat_cnt;
            rd_idx                    <= rd_acc ? idx : rd_idx;
            bus.host_init             <= bus.host_init || (state == INIT && init_cnt == '1);
            bus.host_rd_valid         <= state == RD_RESP;
            bus.host_data_bus_read_in <= state == RD_RESP ? mem[rd_idx] : bus.host_data_bus_read_in;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= wr_data;
    end
endmodule

// File: tb/tb_host_line_responder.sv
// tb_host_line_responder: directed stimulus with a queue scoreboard checking read responses
module tb_host_line_responder;
    localparam int LAT = 4;
    localparam int W   = 512;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    int           cyc = 0, tests = 0, fails = 0, last_acc = 0, w_acc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] d2, pa, p55, junk;
    host_line_if #(.ADDR_BITCOUNT(64), .CL_SIZE_WIDTH(W)) hif();
    host_line_responder #(.RD_LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(hif.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (hif.host_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_valid_unexpected: got pulse at cycle %0d, want none", cyc);
            end else begin
                chk("rd_data", hif.host_data_bus_read_in, exp_q.pop_front());
                chk("rd_latency", W'(cyc - last_acc), W'(LAT));
            end
        end
    end
    task automatic wait_open();
        int n = 0;
        @(negedge clk);
        while (!hif.host_rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", W'(hif.host_rd_ready), W'(1));
    endtask
    task automatic do_write(input logic [63:0] a, input logic [W-1:0] d);
        wait_open();
        hif.host_we = 1'b1;
        hif.corrected_address = a;
        hif.host_data_bus_write_out = d;
        @(posedge clk); #1;
        hif.host_we = 1'b0;
        chk("wr_busy_ready", W'({hif.host_rd_ready, hif.host_wr_ready}), W'(0));
    endtask
    task automatic do_read(input logic [63:0] a, input logic [W-1:0] e);
        wait_open();
        exp_q.push_back(e);
        hif.host_re = 1'b1;
        hif.corrected_address = a;
        @(posedge clk); #1;
        last_acc = cyc;
        hif.host_re = 1'b0;
        chk("rd_busy_ready", W'({hif.host_rd_ready, hif.host_wr_ready}), W'(0));
    endtask
    task automatic wait_init(input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!hif.host_init && n < 200);
        chk(name, W'(n), W'(64));
        chk({name, "_ready"}, W'({hif.host_rd_ready, hif.host_wr_ready}), W'(2'b11));
    endtask
    task automatic chk_cleared(input string name);
        chk({name, "_init"}, W'(hif.host_init), W'(0));
        chk({name, "_ready"}, W'({hif.host_rd_ready, hif.host_wr_ready}), W'(0));
        chk({name, "_valid"}, W'(hif.host_rd_valid), W'(0));
        chk({name, "_data"}, hif.host_data_bus_read_in, '0);
    endtask
    initial begin
        hif.host_re = 1'b0;
        hif.host_we = 1'b0;
        hif.corrected_address = '0;
        hif.host_data_bus_write_out = '0;
        d2   = {480'd0, 32'hDEADBEEF};
        pa   = {16{32'hA5A5_0F0F}};
        p55  = {64{8'h55}};
        junk = {16{32'h1234_5678}};
        #1 rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        wait_init("init_latency");
        do_read(64'h0, '1);
        do_write(64'h80, d2);
        do_read(64'h80, d2);
        do_read(64'hBF, d2);
        do_write(64'h0, pa);
        do_read(64'h1000, pa);
        wait_open();
        exp_q.push_back(p55);
        hif.host_re = 1'b1;
        hif.host_we = 1'b1;
        hif.corrected_address = 64'h40;
        hif.host_data_bus_write_out = p55;
        @(posedge clk); #1;
        w_acc = cyc;
        hif.host_we = 1'b0;
        chk("simul_wr_busy", W'({hif.host_rd_ready, hif.host_wr_ready}), W'(0));
        wait_open();
        @(posedge clk); #1;
        last_acc = cyc;
        hif.host_re = 1'b0;
        chk("simul_rd_gap", W'(cyc - w_acc), W'(2));
        do_read(64'h80, d2);
        hif.host_we = 1'b1;
        hif.host_data_bus_write_out = junk;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            hif.host_we = 1'b0;
            chk("busy_ready", W'({hif.host_rd_ready, hif.host_wr_ready}), W'(0));
        end
        @(posedge clk); #1;
        chk("ready_after_valid", W'({hif.host_rd_ready, hif.host_wr_ready}), W'(2'b11));
        do_read(64'h80, d2);
        do_read(64'h40, p55);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_cleared("midop_reset");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit_latency");
        do_read(64'h80, '1);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/host_line_responder.md
# host_line_responder

Host-side responder for the cache-line host interface driven by `mem_ctrl`. It services `host_re` and `host_we` cache-line requests against an internal line-addressed backing store, and returns 512-bit read data after a fixed, parameterized latency. After reset it runs a memory-fill sequence and then raises `host_init`. It sits opposite `mem_ctrl` in CPU-level benches and replaces the hand-driven host stimulus.

## Interface

**Parameters**
- `ADDR_BITCOUNT`, 64: width of the byte address.
- `CL_SIZE_WIDTH`, 512: cache-line width in bits (64 bytes).
- `DEPTH_LOG2`, 6: log2 of the number of lines in the store.
- `RD_LATENCY`, 4: cycles from read acceptance to `host_rd_valid`. Legal range is 1 to 15.
- `FILL_VALUE`, all ones: contents written to every line during init.

**Ports**
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `host_re`, input, 1: read request; held by the initiator until accepted.
- `host_we`, input, 1: write request; held by the initiator until accepted.
- `corrected_address`, input, `ADDR_BITCOUNT`: byte address of the request.
- `host_data_bus_write_out`, input, `CL_SIZE_WIDTH`: write data.
- `host_init`, output, 1: high once the init fill has completed.
- `host_rd_ready`, output, 1: a read can be accepted this cycle.
- `host_wr_ready`, output, 1: a write can be accepted this cycle.
- `host_rd_valid`, output, 1: one-cycle pulse marking valid read data.
- `host_data_bus_read_in`, output, `CL_SIZE_WIDTH`: read data.

## Operation

**States:** INIT, IDLE, RD_WAIT, RD_RESP, WR_BUSY.

**Line index:** `corrected_address[6 +: DEPTH_LOG2]`. Bits [5:0] and bits above the index are ignored, so addresses wrap modulo the store size.

**INIT**
- Entered on reset.
- Writes `FILL_VALUE` to line `init_cnt`, one line per cycle.
- `init_cnt` runs 0 to 2^DEPTH_LOG2−1.
- After the last line is written: go to IDLE and set `host_init`. `host_init` stays high until the next reset.

**IDLE**
- `host_rd_ready` = `host_wr_ready` = 1.
- `host_we` alone: the line is written at this edge, then go to WR_BUSY.
- `host_re` alone: capture the index, load the latency counter with `RD_LATENCY`−1, then go to RD_WAIT. If `RD_LATENCY` = 1, go directly to RD_RESP.
- `host_re` and `host_we` together: the write is accepted and the read is not. The initiator keeps `host_re` high and the read is accepted on a later IDLE cycle.

**WR_BUSY**
- Lasts one cycle; both readies are 0; return to IDLE.

**RD_WAIT**
- Both readies are 0.
- The counter decrements each cycle. When it reaches 0, go to RD_RESP.

**RD_RESP**
- Drive `host_rd_valid` = 1 for one cycle.
- Drive `host_data_bus_read_in` with the store contents of the captured index.
- Return to IDLE.

**Single-ported store:** no request of either type is accepted while in RD_WAIT, RD_RESP or WR_BUSY.

**Read-after-write:** a read of a line that was just written returns the new data.

**Requests outside IDLE:** `host_re` or `host_we` seen in any non-IDLE state is ignored. It is not queued.

**Data hold:** `host_data_bus_read_in` holds its last read value until the next RD_RESP.

## Timing

**Reset values:** `host_init` = 0, both readies = 0, `host_rd_valid` = 0, `host_data_bus_read_in` = 0. The state is INIT and `init_cnt` = 0.

**Init:** the first edge with `rst_n` high writes line 0. At edge number 2^DEPTH_LOG2, `host_init`, `host_rd_ready` and `host_wr_ready` all go high together.

**Read:** read accepted at edge N.
- Readies are low from N.
- `host_rd_valid` and data are registered at edge N+`RD_LATENCY`.
- Readies are high again at edge N+`RD_LATENCY`+1.
- `host_rd_valid` falls at that same edge.

**Write:** write accepted at edge N.
- The store is updated at N.
- Readies are low from N and high again at N+1.
- The earliest following accept is at edge N+2.

**Reset mid-operation:** asserting `rst_n` low at any time:
- clears all outputs immediately;
- abandons any pending read with no `host_rd_valid` issued;
- returns the block to INIT, which refills the whole store.

**Counter widths:** `init_cnt` is `DEPTH_LOG2` bits; the latency counter is 4 bits.

## Test plan

1. **Reset and init:** hold `rst_n` low for 10 cycles, then release → `host_init` and both readies rise exactly 64 cycles later. Reading address 0x0 then returns all ones.
2. **Write then read:** write 0x…DEADBEEF (low word, rest zero) to address 0x80 → read of 0x80 gives `host_rd_valid` 4 cycles after acceptance with identical data. A read of 0xBF, in the same line, returns the same data.
3. **Wrap-around:** write pattern A to address 0x0, then read 0x1000 (index 0 with DEPTH_LOG2 = 6) → returns pattern A.
4. **Simultaneous requests:** assert `host_re` and `host_we` to 0x40 in the same IDLE cycle, with write data 0x55…55 → write accepted first, read accepted 2 cycles later, read returns 0x55…55, and exactly one `host_rd_valid` pulse.
5. **Request while busy:** pulse `host_we` for one cycle during RD_WAIT → write ignored and the store is unchanged. Readies stay low until 1 cycle after `host_rd_valid`.
6. **Reset mid-operation:** assert reset 2 cycles after a read is accepted → `host_rd_valid` never pulses, all outputs read 0, and the init sequence repeats with `host_init` 64 cycles after release.
